// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback/commit stage.
package wb_commit_pkg;

    // Load/store access width as encoded by issue.
    typedef enum logic [1:0] {
        WORD = 2'd0,
        HALF = 2'd1,
        BYTE = 2'd2
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ALU = 2'd1,
        WAIT_LSU = 2'd2,
        COMMIT   = 2'd3
    } wb_state_e;

    localparam logic [4:0] RF_ZERO_ADDR = 5'd0;

    // Writeback descriptor captured from issue at transfer time.
    typedef struct packed {
        logic       rf_w;
        logic [4:0] waddr;
        logic       soursel;
        logic       data_we;
        lsu_type_e  lsu_type;
        logic       lsu_sign;
        logic [1:0] lsu_offset;
    } wb_desc_t;

    // x0 writes, stores and errored completions never touch the register file.
    function automatic logic rf_write_allowed(input wb_desc_t d, input logic err);
        return d.rf_w && (d.waddr != RF_ZERO_ADDR) && !err && !(d.soursel && d.data_we);
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Extracts and extends the addressed half/byte lane of a word-aligned load
// response, and flags accesses that do not sit on their natural boundary.
module wb_load_align
    import wb_commit_pkg::*;
(
    input  logic [31:0] rdata,
    input  lsu_type_e   lsu_type,
    input  logic        sign,
    input  logic [1:0]  offset,
    output logic [31:0] wdata,
    output logic        misaligned
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    // Lane select, then zero/sign extension by access width.
    always_comb begin
        half_v     = offset[1] ? rdata[31:16] : rdata[15:0];
        case (offset)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        wdata      = rdata;
        misaligned = 1'b0;
        case (lsu_type)
            HALF: begin
                wdata      = {{16{sign & half_v[15]}}, half_v};
                misaligned = offset[0];
            end
            BYTE: wdata = {{24{sign & byte_v[7]}}, byte_v};
            // WORD (and the unused encoding) pass the word through.
            default: misaligned = (offset != 2'd0);
        endcase
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: accepts one descriptor from issue, waits for the
// ALU result or LSU response (with a response timeout), then performs a
// single-cycle register-file write and completion ack.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        req_rf_w_i,
    input  logic [4:0]  rf_waddr_i,
    input  logic        rf_soursel_i,
    input  logic        data_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_i,
    input  logic [1:0]  lsu_offset_i,
    input  logic        alu_valid_i,
    input  logic [31:0] alu_result_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    wb_state_e   state;
    wb_desc_t    desc;
    wb_desc_t    req_desc;
    logic [15:0] to_cnt;
    logic [15:0] cnt_inc;
    logic [31:0] ld_data;
    logic        ld_misaligned;
    logic        done;
    logic        res_err;
    logic [31:0] res;

    assign ready_o = (state == IDLE);
    assign cnt_inc = to_cnt + 16'd1;

    // Formats load data against the captured descriptor, not the live inputs.
    wb_load_align u_align (
        .rdata      (data_rdata_i),
        .lsu_type   (desc.lsu_type),
        .sign       (desc.lsu_sign),
        .offset     (desc.lsu_offset),
        .wdata      (ld_data),
        .misaligned (ld_misaligned)
    );

    // Pack the incoming descriptor fields.
    always_comb begin
        req_desc            = '0;
        req_desc.rf_w       = req_rf_w_i;
        req_desc.waddr      = rf_waddr_i;
        req_desc.soursel    = rf_soursel_i;
        req_desc.data_we    = data_we_i;
        req_desc.lsu_type   = lsu_type_e'(lsu_type_i);
        req_desc.lsu_sign   = lsu_sign_i;
        req_desc.lsu_offset = lsu_offset_i;
    end

    // Completion decision for the wait states; rvalid takes priority over timeout.
    always_comb begin
        done    = 1'b0;
        res_err = 1'b0;
        res     = '0;
        case (state)
            WAIT_ALU: if (alu_valid_i) begin
                done = 1'b1;
                res  = alu_result_i;
            end
            WAIT_LSU: begin
                if (data_rvalid_i) begin
                    done    = 1'b1;
                    res     = ld_data;
                    // Alignment only matters for loads: stores return no data.
                    res_err = data_err_i | (ld_misaligned & ~desc.data_we);
                end else if (cnt_inc == TIMEOUT_LIMIT) begin
                    done    = 1'b1;
                    res_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM with registered commit outputs; write address/data hold until the next commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            desc       <= '0;
            to_cnt     <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            rf_we_o <= 1'b0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE: if (req_i) begin
                    desc  <= req_desc;
                    state <= req_desc.soursel ? WAIT_LSU : WAIT_ALU;
                end
                WAIT_ALU, WAIT_LSU: begin
                    to_cnt <= (state == WAIT_LSU && !done) ? cnt_inc : '0;
                    if (done) begin
                        state      <= COMMIT;
                        ack_o      <= 1'b1;
                        err_o      <= res_err;
                        rf_we_o    <= rf_write_allowed(desc, res_err);
                        rf_waddr_o <= desc.waddr;
                        rf_wdata_o <= res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Directed plus randomized bench for wb_commit against a behavioural model.
module tb_wb_commit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        req_rf_w_i = 1'b0;
    logic [4:0]  rf_waddr_i = '0;
    logic        rf_soursel_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [1:0]  lsu_type_i = '0;
    logic        lsu_sign_i = 1'b0;
    logic [1:0]  lsu_offset_i = '0;
    logic        alu_valid_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;
    logic        ready_o, rf_we_o, ack_o, err_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int checks = 0;
    int failures = 0;

    wb_commit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .ready_o(ready_o),
        .req_rf_w_i(req_rf_w_i), .rf_waddr_i(rf_waddr_i), .rf_soursel_i(rf_soursel_i),
        .data_we_i(data_we_i), .lsu_type_i(lsu_type_i), .lsu_sign_i(lsu_sign_i),
        .lsu_offset_i(lsu_offset_i), .alu_valid_i(alu_valid_i), .alu_result_i(alu_result_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .ack_o(ack_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected completion: cycle index after accept (0 = first cycle after
    // transfer), write enable, write data and error flag.
    function automatic void model(input bit rfw, input logic [4:0] wa, input bit sel,
                                  input bit dwe, input logic [1:0] typ, input bit sgn,
                                  input logic [1:0] off, input int d, input logic [31:0] data,
                                  input bit berr, output int ec, output bit ewe,
                                  output logic [31:0] ewd, output bit eerr);
        longint v;
        ec = d + 1; eerr = 0; ewd = data;
        if (sel) begin
            if (d >= TO) begin
                ec = TO; eerr = 1; ewd = '0;
            end else begin
                case (typ)
                    2'd0: eerr = (off != 0) && !dwe;
                    2'd1: begin
                        v = longint'(data / (off[1] ? 65536 : 1)) % 65536;
                        if (sgn && v >= 32768) v -= 65536;
                        ewd = 32'(v);
                        eerr = off[0] && !dwe;
                    end
                    default: begin
                        v = longint'(data / (32'd1 << (8 * off))) % 256;
                        if (sgn && v >= 128) v -= 256;
                        ewd = 32'(v);
                    end
                endcase
                eerr = eerr || berr;
            end
        end
        ewe = rfw && (wa != 0) && !eerr && !(sel && dwe);
    endfunction

    // One transaction: wait for ready, transfer, respond after d cycles
    // (never, if d is past the timeout), then check the completion.
    task automatic txn(input bit rfw, input logic [4:0] wa, input bit sel, input bit dwe,
                       input logic [1:0] typ, input bit sgn, input logic [1:0] off,
                       input int d, input logic [31:0] data, input bit berr);
        int ec; bit ewe; logic [31:0] ewd; bit eerr;
        int c; int w; bit got;
        model(rfw, wa, sel, dwe, typ, sgn, off, d, data, berr, ec, ewe, ewd, eerr);
        w = 0;
        @(negedge clk);
        while (!ready_o && w < 10) begin @(negedge clk); w++; end
        chk("ready_wait", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        req_i = 1; req_rf_w_i = rfw; rf_waddr_i = wa; rf_soursel_i = sel; data_we_i = dwe;
        lsu_type_i = typ; lsu_sign_i = sgn; lsu_offset_i = off;
        @(posedge clk); #1;
        // Scramble the descriptor inputs: the DUT must use its captured copy.
        req_i = 0; req_rf_w_i = 1'($urandom); rf_waddr_i = 5'($urandom);
        rf_soursel_i = 1'($urandom); data_we_i = 1'($urandom);
        lsu_type_i = 2'($urandom_range(0, 2)); lsu_sign_i = 1'($urandom);
        lsu_offset_i = 2'($urandom);
        got = 0; c = 0;
        while (!got && c <= TO + 4) begin
            alu_valid_i   = !sel && (c == d);
            alu_result_i  = (c == d) ? data : $urandom;
            data_rvalid_i = sel ? (c == d) : 1'($urandom);
            data_rdata_i  = (c == d) ? data : $urandom;
            data_err_i    = (c == d) ? berr : 1'($urandom);
            @(negedge clk);
            if (ack_o) begin
                got = 1;
                chk("ack_cycle", 32'(c), 32'(ec));
                chk("rf_we", 32'(rf_we_o), 32'(ewe));
                chk("err", 32'(err_o), 32'(eerr));
                if (ewe) begin
                    chk("waddr", 32'(rf_waddr_o), 32'(wa));
                    chk("wdata", rf_wdata_o, ewd);
                end
            end else begin
                chk("we_idle", 32'(rf_we_o), 32'd0);
                chk("ready_busy", 32'(ready_o), 32'd0);
            end
            @(posedge clk); #1;
            c++;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        alu_valid_i = 0; data_rvalid_i = 0; data_err_i = 0;
    endtask

    initial begin
        bit sel, dwe;
        logic [1:0] off;
        int d;
        // Reset
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_we", 32'(rf_we_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);

        // Directed cases
        txn(1, 5'd5, 0, 0, 2'd0, 0, 2'd0, 0, 32'hDEADBEEF, 0);
        chk("alu_hold", rf_wdata_o, 32'hDEADBEEF);
        txn(1, 5'd7, 1, 0, 2'd2, 1, 2'd3, 1, 32'h80FF_1234, 0);
        chk("lb_signed", rf_wdata_o, 32'hFFFF_FF80);
        txn(1, 5'd7, 1, 0, 2'd2, 0, 2'd3, 1, 32'h80FF_1234, 0);
        chk("lb_unsigned", rf_wdata_o, 32'h0000_0080);
        txn(1, 5'd4, 1, 1, 2'd0, 0, 2'd0, 4, 32'h1111_2222, 0);
        txn(1, 5'd0, 0, 0, 2'd0, 0, 2'd0, 0, 32'h0000_1234, 0);
        txn(1, 5'd6, 1, 0, 2'd0, 0, 2'd0, 20, 32'h5555_AAAA, 0);
        txn(1, 5'd6, 1, 0, 2'd0, 0, 2'd0, TO - 1, 32'hCAFE_F00D, 0);
        chk("rvalid_on_timeout", rf_wdata_o, 32'hCAFE_F00D);
        txn(1, 5'd8, 1, 0, 2'd1, 0, 2'd1, 2, 32'h1234_5678, 0);
        txn(1, 5'd9, 1, 0, 2'd0, 0, 2'd0, 1, 32'h1234_5678, 1);
        txn(1, 5'd10, 1, 0, 2'd1, 1, 2'd2, 0, 32'h9ABC_0000, 0);

        // Back-to-back: req held high, ALU always valid -> accept every 3 cycles
        @(negedge clk);
        @(posedge clk); #1;
        req_i = 1; req_rf_w_i = 1; rf_waddr_i = 5'd9; rf_soursel_i = 0; data_we_i = 0;
        alu_valid_i = 1; alu_result_i = 32'h0BAD_F00D;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(ready_o), 32'(c % 3 == 0));
            chk("b2b_ack", 32'(ack_o), 32'(c % 3 == 2));
            chk("b2b_we", 32'(rf_we_o), 32'(c % 3 == 2));
            @(posedge clk); #1;
        end
        req_i = 0; alu_valid_i = 0;

        // Reset while waiting on the ALU abandons the instruction
        @(negedge clk);
        @(posedge clk); #1;
        req_i = 1; rf_waddr_i = 5'd3; rf_soursel_i = 0;
        @(posedge clk); #1;
        req_i = 0; rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0; alu_valid_i = 1; alu_result_i = 32'h7777_7777;
        @(negedge clk);
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_wdata", rf_wdata_o, 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("mid_rst_ack", 32'(ack_o), 32'd0);
            chk("mid_rst_we", 32'(rf_we_o), 32'd0);
            @(posedge clk); #1;
            alu_valid_i = 0;
            @(negedge clk);
        end

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom);
            dwe = sel && ($urandom_range(0, 2) == 0);
            off = dwe ? 2'd0 : 2'($urandom);
            d   = sel ? $urandom_range(0, TO + 1) : $urandom_range(0, 4);
            txn(1'($urandom_range(0, 7) != 0), 5'($urandom), sel, dwe,
                dwe ? 2'd0 : 2'($urandom_range(0, 2)), 1'($urandom), off, d,
                $urandom, $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
